multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Sequencing FSM for the RV32I multi-cycle datapath; replaces the single-cycle decoder.
- Splits every instruction into FETCH / DECODE / execute / memory / writeback states.
- Drives the datapath strobes: PC enable, instruction-register enable, register-file write, ALU control and mux selects.
- Drives a request/ready handshake toward the data bus, so memory may insert wait states.

Parameters:
TIMEOUT_CYCLES, 16, max busReq cycles without busReady before abort (used only with BUS_TIMEOUT_EN)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
instrCode  input  32  instruction-register output from datapath
busReady  input  1  data-bus slave done; read data valid the same cycle and held until next busReq
PCEn  output  1  PC register load enable
instrRegEn  output  1  instruction register load enable
regFileWe  output  1  register-file write enable
aluControl  output  4  ALU operation {func7[5], func3} encoding
aluSrcMuxSel  output  1  0 = RFData2, 1 = immExt
RFWDSrcMuxSel  output  3  0 alu, 1 busRData, 2 immExt, 3 PC+imm, 4 PC+4
branch  output  1  conditional branch qualifier
jal  output  1  unconditional PC+imm select
jalr  output  1  PC-imm adder base = RFData1
busReq  output  1  data-bus request
busWe  output  1  data-bus write (valid with busReq)
busErr  output  1  one-cycle bus-timeout pulse

Behaviour:
- Interface: single clock clk; reset is synchronous and active-high.
- Reset: state = FETCH. Every output is 0 in the reset cycle.
- Moore outputs, decoded from the state register and instrCode.
- Unlisted outputs are 0 in every state. aluControl defaults to ADD (4'b0000).
- FETCH:
  - instrRegEn = 1.
  - Next state: DECODE.
- DECODE: branch on opcode:
  - R 0110011 -> R_EXE
  - I 0010011 -> I_EXE
  - L 0000011 -> L_MEM
  - S 0100011 -> S_MEM
  - B 1100011 -> B_EXE
  - LU 0110111 -> LU_EXE
  - AU 0010111 -> AU_EXE
  - J 1101111 -> J_EXE
  - JL 1100111 -> JL_EXE
  - Any other opcode: treat as NOP. PCEn = 1 in DECODE, PC+4 selected, next state FETCH.
- Execute states: each lasts 1 cycle, asserts PCEn = 1, then goes to FETCH.
  - R_EXE: regFileWe = 1, aluSrcMuxSel = 0, RFWDSrcMuxSel = 0, aluControl = {instrCode[30], func3}.
  - I_EXE: regFileWe = 1, aluSrcMuxSel = 1, RFWDSrcMuxSel = 0. aluControl = {instrCode[30], func3} when func3 = 101, else {0, func3}.
  - B_EXE: branch = 1, aluSrcMuxSel = 0, aluControl = {0, func3}.
  - LU_EXE: regFileWe = 1, RFWDSrcMuxSel = 2.
  - AU_EXE: regFileWe = 1, RFWDSrcMuxSel = 3.
  - J_EXE: jal = 1, regFileWe = 1, RFWDSrcMuxSel = 4.
  - JL_EXE: jal = 1, jalr = 1, regFileWe = 1, RFWDSrcMuxSel = 4, aluSrcMuxSel = 1.
- S_MEM:
  - busReq = 1, busWe = 1, aluSrcMuxSel = 1, aluControl = ADD.
  - Hold until busReady = 1. In that cycle PCEn = 1 and next state is FETCH.
- L_MEM:
  - busReq = 1, busWe = 0, aluSrcMuxSel = 1, aluControl = ADD.
  - Hold until busReady = 1, then go to L_WB.
- L_WB: regFileWe = 1, RFWDSrcMuxSel = 1, PCEn = 1. Next state: FETCH.
- Latency with w wait states:
  - ALU, branch and jump instructions: 3 cycles.
  - Store: 3 + w cycles.
  - Load: 4 + w cycles.
- PCEn is asserted exactly once per instruction, always in its final cycle.
- busReady outside S_MEM/L_MEM is ignored.
- Reset during any state, including mid-handshake:
  - busReq drops in the reset cycle.
  - No register-file write or PC load occurs in that cycle.
  - FETCH follows reset release.
- regFileWe is never asserted in FETCH, DECODE, S_MEM or L_MEM.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to S_MEM/L_MEM and increments each cycle busReady = 0.
  - When it reaches TIMEOUT_CYCLES-1 with busReady still 0, the request is aborted: busErr = 1 for one cycle, PCEn = 1 (skip instruction, PC+4), no register-file write, next state FETCH.
  - If busReady and timeout coincide, busReady wins and the access completes normally.
- Undefined: no counter is built, busErr is tied to 0, and the FSM waits indefinitely for busReady.

Test Plan:
- Reset held 2 cycles, then ADD x3,x1,x2 (0x002081B3) -> FETCH/DECODE/R_EXE; R_EXE shows regFileWe = 1, aluControl = 0000, PCEn = 1; 3 cycles total.
- SUB 0x402081B3 then SRAI 0x4020D193 -> aluControl 1000 then 1101; aluSrcMuxSel 0 then 1.
- LW 0x0000A183 with busReady delayed 2 cycles -> busReq high 3 cycles, busWe = 0; L_WB shows regFileWe = 1, RFWDSrcMuxSel = 1, PCEn = 1; 6 cycles total.
- SW 0x0030A023 with busReady = 1 on the first S_MEM cycle -> busReq = busWe = 1 for 1 cycle, PCEn in the same cycle, regFileWe never 1.
- BEQ 0x00208463 then JALR 0x000080E7 -> B_EXE: branch = 1, aluControl = 0000, regFileWe = 0. JL_EXE: jal = jalr = 1, RFWDSrcMuxSel = 4, regFileWe = 1.
- Reset asserted in the 2nd L_MEM wait cycle -> next cycle all outputs 0, then FETCH. With BUS_TIMEOUT_EN and busReady stuck 0: busErr pulses on the 16th busReq cycle, PCEn = 1, regFileWe = 0.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Data-bus request/ready handshake between the multi-cycle control unit
// (master) and the data memory (slave). busErr reports an aborted request.
interface multicycle_control_unit_if;
    logic busReq;
    logic busWe;
    logic busErr;
    logic busReady;

    modport master (
        output busReq,
        output busWe,
        output busErr,
        input  busReady
    );

    modport slave (
        input  busReq,
        input  busWe,
        input  busErr,
        output busReady
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Sequencing FSM for the RV32I multi-cycle datapath. Every instruction runs
// FETCH -> DECODE -> execute/memory -> (writeback). Datapath strobes are Moore
// decodes of the state register and instrCode, forced to 0 while reset is high.
// The memory states qualify PCEn with busReady so a store or an abort retires
// in the same cycle the bus answers.
//
// Optional build macro BUS_TIMEOUT_EN: adds a wait counter that aborts a data
// access after TIMEOUT_CYCLES request cycles without busReady (busErr pulse,
// instruction skipped). Without it the FSM waits for busReady indefinitely.
//
// state  | meaning
// FETCH  | load instruction register
// DECODE | dispatch on opcode; unknown opcode retires here as a NOP
// R_EXE  | register-register ALU op, write back ALU result
// I_EXE  | register-immediate ALU op, write back ALU result
// B_EXE  | conditional branch compare
// LU_EXE | LUI, write back immExt
// AU_EXE | AUIPC, write back PC+imm
// J_EXE  | JAL, write back PC+4
// JL_EXE | JALR, write back PC+4, target based on RFData1
// S_MEM  | store request, held until busReady
// L_MEM  | load request, held until busReady
// L_WB   | write load data to register file
module multicycle_control_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [31:0]                       instrCode_i,
    output logic                              PCEn_o,
    output logic                              instrRegEn_o,
    output logic                              regFileWe_o,
    output logic [3:0]                        aluControl_o,
    output logic                              aluSrcMuxSel_o,
    output logic [2:0]                        RFWDSrcMuxSel_o,
    output logic                              branch_o,
    output logic                              jal_o,
    output logic                              jalr_o,
    multicycle_control_unit_if.master         bus
);

    typedef enum logic [3:0] {
        FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE,
        J_EXE, JL_EXE, S_MEM, L_MEM, L_WB
    } state_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_L  = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_LU = 7'b0110111;
    localparam logic [6:0] OP_AU = 7'b0010111;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_JL = 7'b1100111;

    state_t     state_q;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       func7_b5;
    logic       in_mem;
    logic       timeout;
    logic       unused_instr_bits;

    assign opcode            = instrCode_i[6:0];
    assign func3             = instrCode_i[14:12];
    assign func7_b5          = instrCode_i[30];
    assign in_mem            = (state_q == S_MEM) || (state_q == L_MEM);
    assign unused_instr_bits = ^{instrCode_i[31], instrCode_i[29:15], instrCode_i[11:7]};

`ifdef BUS_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] wait_cnt_q;

    // busReady wins over a coinciding timeout, hence the !busReady term
    assign timeout = in_mem && !bus.busReady && (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Wait counter: held at 0 outside the memory states, so it starts at 0 on entry
    always_ff @(posedge clk) begin
        if (reset || !in_mem) begin
            wait_cnt_q <= '0;
        end else if (!bus.busReady) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
`endif

    // State register and next-state sequencing
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            case (state_q)
                FETCH:  state_q <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_R:    state_q <= R_EXE;
                        OP_I:    state_q <= I_EXE;
                        OP_L:    state_q <= L_MEM;
                        OP_S:    state_q <= S_MEM;
                        OP_B:    state_q <= B_EXE;
                        OP_LU:   state_q <= LU_EXE;
                        OP_AU:   state_q <= AU_EXE;
                        OP_J:    state_q <= J_EXE;
                        OP_JL:   state_q <= JL_EXE;
                        default: state_q <= FETCH;
                    endcase
                end
                S_MEM:  if (bus.busReady || timeout) state_q <= FETCH;
                L_MEM: begin
                    if (bus.busReady)  state_q <= L_WB;
                    else if (timeout)  state_q <= FETCH;
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    // Output decode from the state register; everything is 0 while reset is high
    always_comb begin
        PCEn_o          = 1'b0;
        instrRegEn_o    = 1'b0;
        regFileWe_o     = 1'b0;
        aluControl_o    = 4'b0000;
        aluSrcMuxSel_o  = 1'b0;
        RFWDSrcMuxSel_o = 3'd0;
        branch_o        = 1'b0;
        jal_o           = 1'b0;
        jalr_o          = 1'b0;
        bus.busReq      = 1'b0;
        bus.busWe       = 1'b0;
        bus.busErr      = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH:  instrRegEn_o = 1'b1;
                DECODE: begin
                    case (opcode)
                        OP_R, OP_I, OP_L, OP_S, OP_B,
                        OP_LU, OP_AU, OP_J, OP_JL: PCEn_o = 1'b0;
                        default:                   PCEn_o = 1'b1;
                    endcase
                end
                R_EXE: begin
                    PCEn_o       = 1'b1;
                    regFileWe_o  = 1'b1;
                    aluControl_o = {func7_b5, func3};
                end
                I_EXE: begin
                    PCEn_o         = 1'b1;
                    regFileWe_o    = 1'b1;
                    aluSrcMuxSel_o = 1'b1;
                    // only the shift-right pair uses bit 30 to pick SRAI over SRLI
                    aluControl_o   = (func3 == 3'b101) ? {func7_b5, func3} : {1'b0, func3};
                end
                B_EXE: begin
                    PCEn_o       = 1'b1;
                    branch_o     = 1'b1;
                    aluControl_o = {1'b0, func3};
                end
                LU_EXE: begin
                    PCEn_o          = 1'b1;
                    regFileWe_o     = 1'b1;
                    RFWDSrcMuxSel_o = 3'd2;
                end
                AU_EXE: begin
                    PCEn_o          = 1'b1;
                    regFileWe_o     = 1'b1;
                    RFWDSrcMuxSel_o = 3'd3;
                end
                J_EXE: begin
                    PCEn_o          = 1'b1;
                    jal_o           = 1'b1;
                    regFileWe_o     = 1'b1;
                    RFWDSrcMuxSel_o = 3'd4;
                end
                JL_EXE: begin
                    PCEn_o          = 1'b1;
                    jal_o           = 1'b1;
                    jalr_o          = 1'b1;
                    regFileWe_o     = 1'b1;
                    RFWDSrcMuxSel_o = 3'd4;
                    aluSrcMuxSel_o  = 1'b1;
                end
                S_MEM: begin
                    bus.busReq     = 1'b1;
                    bus.busWe      = 1'b1;
                    aluSrcMuxSel_o = 1'b1;
                    PCEn_o         = bus.busReady || timeout;
                    bus.busErr     = timeout;
                end
                L_MEM: begin
                    bus.busReq     = 1'b1;
                    aluSrcMuxSel_o = 1'b1;
                    PCEn_o         = timeout;
                    bus.busErr     = timeout;
                end
                L_WB: begin
                    PCEn_o          = 1'b1;
                    regFileWe_o     = 1'b1;
                    RFWDSrcMuxSel_o = 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit. All outputs are
// packed into one vector {PCEn, instrRegEn, regFileWe, aluControl, aluSrc,
// RFWDSrc, branch, jal, jalr, busReq, busWe, busErr} and compared against
// hand-computed vectors. Inputs change 2 time units after the rising edge,
// outputs are sampled 1 unit later, well before the falling edge.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instrCode;
    logic        PCEn, instrRegEn, regFileWe, aluSrcMuxSel, branch, jal, jalr;
    logic [3:0]  aluControl;
    logic [2:0]  RFWDSrcMuxSel;
    logic [16:0] obs;
    logic [16:0] exp_v;
    int          n_chk  = 0;
    int          n_fail = 0;

    multicycle_control_unit_if bus_if ();

    multicycle_control_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .instrCode_i     (instrCode),
        .PCEn_o          (PCEn),
        .instrRegEn_o    (instrRegEn),
        .regFileWe_o     (regFileWe),
        .aluControl_o    (aluControl),
        .aluSrcMuxSel_o  (aluSrcMuxSel),
        .RFWDSrcMuxSel_o (RFWDSrcMuxSel),
        .branch_o        (branch),
        .jal_o           (jal),
        .jalr_o          (jalr),
        .bus             (bus_if)
    );

    always #5 clk = ~clk;

    assign obs = {PCEn, instrRegEn, regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel,
                  branch, jal, jalr, bus_if.busReq, bus_if.busWe, bus_if.busErr};

    function automatic logic [16:0] ev(input logic pc, input logic ir, input logic we,
                                       input logic [3:0] alu, input logic src,
                                       input logic [2:0] wd, input logic br,
                                       input logic jl, input logic jr, input logic req,
                                       input logic bwe, input logic err);
        return {pc, ir, we, alu, src, wd, br, jl, jr, req, bwe, err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_if.busReady = 1'b0;
        instrCode = 32'h0;
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            n_chk++;
            if (obs !== 17'b0) begin
                n_fail++;
                $display("FAIL reset_cycle%0d: got %b want %b", i, obs, 17'b0);
            end
        end
        reset = 1'b0;
    endtask

    // ADD x3,x1,x2: FETCH / DECODE / R_EXE
    task automatic test_add();
        instrCode = 32'h002081B3;
        exp_v = ev(0,1,0,4'b0000,0,3'd0,0,0,0,0,0,0); #1; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL add_fetch: got %b want %b", obs, exp_v); end
        tick(); exp_v = 17'b0; #1; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL add_decode: got %b want %b", obs, exp_v); end
        tick(); exp_v = ev(1,0,1,4'b0000,0,3'd0,0,0,0,0,0,0); #1; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL add_exe: got %b want %b", obs, exp_v); end
        tick();
    endtask

    // SUB then SRAI: bit 30 reaches aluControl in both R and I shift forms
    task automatic test_sub_srai();
        logic [31:0] ins [2];
        logic [16:0] exe [2];
        ins[0] = 32'h402081B3; exe[0] = ev(1,0,1,4'b1000,0,3'd0,0,0,0,0,0,0);
        ins[1] = 32'h4020D193; exe[1] = ev(1,0,1,4'b1101,1,3'd0,0,0,0,0,0,0);
        for (int k = 0; k < 2; k++) begin
            instrCode = ins[k];
            exp_v = ev(0,1,0,4'b0000,0,3'd0,0,0,0,0,0,0); #1; n_chk++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL subsrai_fetch%0d: got %b want %b", k, obs, exp_v); end
            tick(); tick(); exp_v = exe[k]; #1; n_chk++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL subsrai_exe%0d: got %b want %b", k, obs, exp_v); end
            tick();
        end
    endtask

    // Remaining single-cycle execute forms from a table
    task automatic test_exec_table();
        logic [31:0] ins [7];
        logic [16:0] exe [7];
        ins[0] = 32'h40008093; exe[0] = ev(1,0,1,4'b0000,1,3'd0,0,0,0,0,0,0); // ADDI, imm bit30 set
        ins[1] = 32'h0020A093; exe[1] = ev(1,0,1,4'b0010,1,3'd0,0,0,0,0,0,0); // SLTI
        ins[2] = 32'h4020D1B3; exe[2] = ev(1,0,1,4'b1101,0,3'd0,0,0,0,0,0,0); // SRA
        ins[3] = 32'h000011B7; exe[3] = ev(1,0,1,4'b0000,0,3'd2,0,0,0,0,0,0); // LUI
        ins[4] = 32'h00001197; exe[4] = ev(1,0,1,4'b0000,0,3'd3,0,0,0,0,0,0); // AUIPC
        ins[5] = 32'h008000EF; exe[5] = ev(1,0,1,4'b0000,0,3'd4,0,1,0,0,0,0); // JAL
        ins[6] = 32'h00209463; exe[6] = ev(1,0,0,4'b0001,0,3'd0,1,0,0,0,0,0); // BNE
        for (int k = 0; k < 7; k++) begin
            instrCode = ins[k];
            exp_v = ev(0,1,0,4'b0000,0,3'd0,0,0,0,0,0,0); #1; n_chk++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL table%0d_fetch: got %b want %b", k, obs, exp_v); end
            tick(); exp_v = 17'b0; #1; n_chk++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL table%0d_decode: got %b want %b", k, obs, exp_v); end
            tick(); exp_v = exe[k]; #1; n_chk++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL table%0d_exe: got %b want %b", k, obs, exp_v); end
            tick();
        end
    endtask

    // LW with two wait states: 6 cycles, busReq for 3
    task automatic test_load();
        instrCode = 32'h0000A183;
        bus_if.busReady = 1'b0;
        exp_v = ev(0,1,0,4'b0000,0,3'd0,0,0,0,0,0,0); #1; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL lw_fetch: got %b want %b", obs, exp_v); end
        tick(); exp_v = 17'b0; #1; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL lw_decode: got %b want %b", obs, exp_v); end
        for (int w = 0; w < 3; w++) begin
            tick();
            bus_if.busReady = (w == 2);
            exp_v = ev(0,0,0,4'b0000,1,3'd0,0,0,0,1,0,0); #1; n_chk++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL lw_mem%0d: got %b want %b", w, obs, exp_v); end
        end
        tick(); bus_if.busReady = 1'b0;
        exp_v = ev(1,0,1,4'b0000,0,3'd1,0,0,0,0,0,0); #1; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL lw_wb: got %b want %b", obs, exp_v); end
        tick();
    endtask

    // SW answered immediately; busReady already high in FETCH/DECODE is ignored
    task automatic test_store();
        instrCode = 32'h0030A023;
        bus_if.busReady = 1'b1;
        exp_v = ev(0,1,0,4'b0000,0,3'd0,0,0,0,0,0,0); #1; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL sw_fetch: got %b want %b", obs, exp_v); end
        tick(); exp_v = 17'b0; #1; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL sw_decode: got %b want %b", obs, exp_v); end
        tick(); exp_v = ev(1,0,0,4'b0000,1,3'd0,0,0,0,1,1,0); #1; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL sw_mem: got %b want %b", obs, exp_v); end
        tick(); bus_if.busReady = 1'b0;
    endtask

    // BEQ then JALR, then an unknown opcode retiring in DECODE
    task automatic test_branch_jalr_nop();
        instrCode = 32'h00208463;
        tick(); tick(); exp_v = ev(1,0,0,4'b0000,0,3'd0,1,0,0,0,0,0); #1; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL beq_exe: got %b want %b", obs, exp_v); end
        tick(); instrCode = 32'h000080E7;
        tick(); tick(); exp_v = ev(1,0,1,4'b0000,1,3'd4,0,1,1,0,0,0); #1; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL jalr_exe: got %b want %b", obs, exp_v); end
        tick(); instrCode = 32'h00000000;
        tick(); exp_v = ev(1,0,0,4'b0000,0,3'd0,0,0,0,0,0,0); #1; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL nop_decode: got %b want %b", obs, exp_v); end
        tick(); exp_v = ev(0,1,0,4'b0000,0,3'd0,0,0,0,0,0,0); #1; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL nop_refetch: got %b want %b", obs, exp_v); end
    endtask

    // Reset in the 2nd L_MEM wait cycle, then a full load after release
    task automatic test_reset_mid_handshake();
        instrCode = 32'h0000A183;
        bus_if.busReady = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        exp_v = 17'b0; #1; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL rst_mid: got %b want %b", obs, exp_v); end
        tick(); reset = 1'b0;
        exp_v = ev(0,1,0,4'b0000,0,3'd0,0,0,0,0,0,0); #1; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL rst_mid_fetch: got %b want %b", obs, exp_v); end
        tick(); tick(); bus_if.busReady = 1'b1;
        exp_v = ev(0,0,0,4'b0000,1,3'd0,0,0,0,1,0,0); #1; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL rst_mid_mem: got %b want %b", obs, exp_v); end
        tick(); bus_if.busReady = 1'b0; tick();
    endtask

    // Long bus stall: aborts after 16 request cycles with the timeout build,
    // otherwise the FSM keeps waiting
    task automatic test_bus_wait();
        instrCode = 32'h0000A183;
        bus_if.busReady = 1'b0;
        tick();
`ifdef BUS_TIMEOUT_EN
        for (int c = 1; c <= 16; c++) begin
            tick();
            exp_v = (c == 16) ? ev(1,0,0,4'b0000,1,3'd0,0,0,0,1,0,1)
                              : ev(0,0,0,4'b0000,1,3'd0,0,0,0,1,0,0);
            #1; n_chk++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL lw_timeout_c%0d: got %b want %b", c, obs, exp_v); end
        end
        tick(); exp_v = ev(0,1,0,4'b0000,0,3'd0,0,0,0,0,0,0); #1; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL lw_timeout_fetch: got %b want %b", obs, exp_v); end
        instrCode = 32'h0030A023;
        tick();
        for (int c = 1; c <= 16; c++) begin
            tick();
            bus_if.busReady = (c == 16);
            exp_v = (c == 16) ? ev(1,0,0,4'b0000,1,3'd0,0,0,0,1,1,0)
                              : ev(0,0,0,4'b0000,1,3'd0,0,0,0,1,1,0);
            #1; n_chk++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL sw_coincide_c%0d: got %b want %b", c, obs, exp_v); end
        end
        tick(); bus_if.busReady = 1'b0;
`else
        for (int c = 1; c <= 21; c++) begin
            tick();
            bus_if.busReady = (c == 21);
            exp_v = ev(0,0,0,4'b0000,1,3'd0,0,0,0,1,0,0);
            #1; n_chk++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL lw_stall_c%0d: got %b want %b", c, obs, exp_v); end
        end
        tick(); bus_if.busReady = 1'b0;
        exp_v = ev(1,0,1,4'b0000,0,3'd1,0,0,0,0,0,0); #1; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL lw_stall_wb: got %b want %b", obs, exp_v); end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_srai();
        test_exec_table();
        test_load();
        test_store();
        test_branch_jalr_nop();
        test_reset_mid_handshake();
        test_bus_wait();
        exp_v = ev(0,1,0,4'b0000,0,3'd0,0,0,0,0,0,0); #1; n_chk++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL final_fetch: got %b want %b", obs, exp_v); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
